spi_mem_reader: RTL and testbench

- SPI mode-0 master that fetches 1-4 bytes from an external SPI memory using the standard READ command (0x03 + 24-bit address), for instruction/data fetch in the MCU.
- It is the input-side counterpart to the MCU's output drivers: it reads external memory onto an internal response bus.
- It sits between the core's fetch/load unit (valid/ready request, single-cycle response pulse) and the dedicated IO pins (CS_n/SCK/MOSI out, MISO in).

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sck_gen.sv | 50 +++++
 rtl/spi_mem_reader.sv | 140 ++++++++++++++
 tb/tb_spi_mem_reader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory reader: FSM states and READ command framing.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int         SPI_ADDR_W   = 24;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider: toggles sck every CLK_DIV cycles while enabled, flags the edge that is about
// to happen with rise/fall strobes, and parks low with a cleared counter when disabled.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sck_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);
  localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tick;

  // A strobe is high in the cycle whose closing clk edge changes sck.
  assign tick       = en_i && (cnt_q == CNT_MAX);
  assign rise_stb_o = tick && !sck_q;
  assign fall_stb_o = tick && sck_q;
  assign sck_o      = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tick) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_mem_reader.sv
// SPI mode-0 master issuing READ (0x03 + 24-bit address) and returning 1-4 data bytes
// little-endian on a single-cycle response pulse.
module spi_mem_reader
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic [1:0]            req_nbytes,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  spi_cs_n,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);
  localparam int            HW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(CLK_DIV - 1);

  spi_state_e    state_q, state_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          cs_n_q, cs_n_d;
  logic [31:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic [5:0]    bit_q, bit_d;
  logic [1:0]    nbytes_q, nbytes_d;
  logic [HW-1:0] hold_q, hold_d;

  logic       rise_stb, fall_stb;
  logic [5:0] last_bit;
  logic [4:0] rx_idx;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (state_q == ST_SHIFT),
    .sck_o      (spi_sck),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  // Last bit index is 31 + 8*n; data bit j = bit_q-32 lands in byte j/8, MSB first.
  assign last_bit = 6'd39 + {1'b0, nbytes_q, 3'b000};
  assign rx_idx   = {bit_q[4:3], ~bit_q[2:0]};

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    cs_n_d      = cs_n_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_d       = bit_q;
    nbytes_d    = nbytes_q;
    hold_d      = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          state_d  = ST_SHIFT;
          ready_d  = 1'b0;
          cs_n_d   = 1'b0;
          tx_d     = {SPI_CMD_READ, req_addr};
          rx_d     = '0;
          bit_d    = '0;
          nbytes_d = req_nbytes;
        end
      end
      ST_SHIFT: begin
        if (rise_stb && bit_q[5]) begin
          rx_d[rx_idx] = spi_miso;
        end
        if (fall_stb) begin
          if (bit_q == last_bit) begin
            state_d     = ST_DONE;
            cs_n_d      = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_q;
          end else begin
            bit_d = bit_q + 6'd1;
            tx_d  = {tx_q[30:0], 1'b0};
          end
        end
      end
      ST_DONE: begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end
      ST_HOLD: begin
        if (hold_q == HOLD_MAX) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cs_n_q      <= 1'b1;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_q       <= '0;
      nbytes_q    <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cs_n_q      <= cs_n_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      nbytes_q    <= nbytes_d;
      hold_q      <= hold_d;
    end
  end

  // MOSI is the top of the shift register; it is zero once the header is out.
  assign spi_mosi  = tx_q[31];
  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign spi_cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_mem_reader.sv
// Bench for spi_mem_reader: one CLK_DIV=2 and one CLK_DIV=1 instance, each talking to a
// behavioural SPI memory; checks timing, data, MOSI framing and pin invariants.
module tb_spi_mem_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [23:0] req_addr   [2];
  logic [1:0]  req_nbytes [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_data   [2];
  logic        spi_cs_n   [2];
  logic        spi_sck    [2];
  logic        spi_mosi   [2];
  logic        spi_miso   [2] = '{1'b0, 1'b0};

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  string cur_tag = "init";

  int        cslow  [2] = '{0, 0};
  int        rises  [2] = '{0, 0};
  int        bitc   [2] = '{0, 0};
  int        viol   [2] = '{0, 0};
  int        rspcnt [2] = '{0, 0};
  bit [31:0] hdr    [2] = '{32'd0, 32'd0};
  bit        sck_p  [2] = '{1'b0, 1'b0};
  bit        cs_p   [2] = '{1'b0, 1'b0};
  bit        rv_p   [2] = '{1'b0, 1'b0};

  typedef struct {
    int          idx;
    logic [23:0] addr;
    logic [1:0]  nb;
    int          lat;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [6];

  spi_mem_reader #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_nbytes(req_nbytes[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .spi_cs_n(spi_cs_n[0]), .spi_sck(spi_sck[0]), .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso[0])
  );

  spi_mem_reader #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_nbytes(req_nbytes[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .spi_cs_n(spi_cs_n[1]), .spi_sck(spi_sck[1]), .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input int idx);
    return (idx == 0) ? 2 : 1;
  endfunction

  // Memory contents: a[7:0]^0xA5, except address 0x10 which holds 0x5A.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return (a == 24'h000010) ? 8'h5A : (a[7:0] ^ 8'hA5);
  endfunction

  function automatic logic miso_bit(input logic [23:0] a, input int j);
    logic [7:0] b;
    b = mem_byte(a + 24'(j / 8));
    return b[7 - (j % 8)];
  endfunction

  function automatic logic [31:0] exp_data(input logic [23:0] a, input int nb);
    logic [31:0] e;
    e = '0;
    for (int k = 0; k <= nb; k++) e[8*k +: 8] = mem_byte(a + 24'(k));
    return e;
  endfunction

  function automatic int exp_lat(input int idx, input int nb);
    return 1 + 2 * div_of(idx) * (32 + 8 * (nb + 1));
  endfunction

  // SPI memory model and pin monitor, sampled between clk edges.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      sck_p[k] <= spi_sck[k];
      cs_p[k]  <= spi_cs_n[k];
      rv_p[k]  <= rsp_valid[k];
      if (!spi_cs_n[k]) cslow[k] <= cslow[k] + 1;
      if (rsp_valid[k]) rspcnt[k] <= rspcnt[k] + 1;
      if ((spi_cs_n[k] && spi_sck[k]) || (rsp_valid[k] && rv_p[k]) ||
          (!spi_cs_n[k] && spi_sck[k] && !sck_p[k] && bitc[k] >= 32 && spi_mosi[k]))
        viol[k] <= viol[k] + 1;
      if (spi_sck[k] && !sck_p[k]) rises[k] <= rises[k] + 1;
      if (!spi_cs_n[k] && cs_p[k]) begin
        bitc[k] <= 0;
        hdr[k]  <= '0;
      end else if (!spi_cs_n[k] && spi_sck[k] && !sck_p[k]) begin
        bitc[k] <= bitc[k] + 1;
        if (bitc[k] < 32) hdr[k] <= {hdr[k][30:0], spi_mosi[k]};
      end else if (!spi_cs_n[k] && !spi_sck[k] && sck_p[k] && bitc[k] >= 32) begin
        spi_miso[k] <= miso_bit(hdr[k][23:0], bitc[k] - 32);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s: got=0x%0h want=0x%0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic timeout(input string what);
    total++;
    bad++;
    $display("FAIL %s/%s: timeout, no DUT event within budget", cur_tag, what);
  endtask

  task automatic do_read(input int idx, input logic [23:0] a, input logic [1:0] nb,
                         input int lat, input logic [31:0] exp_d);
    int d, b, t_acc, t_rsp, r0, c0, budget;
    d = div_of(idx);
    b = 32 + 8 * (int'(nb) + 1);
    @(negedge clk);
    req_valid[idx] = 1'b1;
    req_addr[idx] = a;
    req_nbytes[idx] = nb;
    budget = 1000;
    while (!req_ready[idx]) begin
      @(negedge clk);
      budget--;
      if (budget == 0) begin timeout("accept"); req_valid[idx] = 1'b0; return; end
    end
    t_acc = cyc;
    r0 = rises[idx];
    c0 = cslow[idx];
    @(negedge clk);
    req_valid[idx] = 1'b0;
    req_addr[idx] = 24'($urandom);
    req_nbytes[idx] = 2'($urandom);
    chk("ready_drop", req_ready[idx], 0);
    chk("cs_low", spi_cs_n[idx], 0);
    budget = 2000;
    while (!rsp_valid[idx]) begin
      @(negedge clk);
      budget--;
      if (budget == 0) begin timeout("rsp"); return; end
    end
    t_rsp = cyc;
    chk("latency", t_rsp - t_acc, lat);
    chk("rsp_data", rsp_data[idx], exp_d);
    chk("mosi_hdr", hdr[idx], {8'h03, a});
    chk("sck_rises", rises[idx] - r0, b);
    chk("cs_low_cycles", cslow[idx] - c0, 2 * d * b);
    $display("read %s dut%0d addr=%06h nb=%0d data=%08h lat=%0d", cur_tag, idx, a, nb,
             rsp_data[idx], t_rsp - t_acc);
    @(negedge clk);
    chk("rsp_pulse", rsp_valid[idx], 0);
    chk("rsp_hold", rsp_data[idx], exp_d);
    budget = 100;
    while (!req_ready[idx]) begin
      @(negedge clk);
      budget--;
      if (budget == 0) begin timeout("ready_back"); return; end
    end
    chk("ready_back", cyc - t_rsp, d + 1);
  endtask

  initial begin
    int r0 [2];
    int c0 [2];
    int t1, t_done, t2, hi_cnt, budget, rv0;
    bit cs_glitch;

    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_addr[k] = '0;
      req_nbytes[k] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    cur_tag = "reset";
    for (int k = 0; k < 2; k++) begin
      chk("req_ready", req_ready[k], 1);
      chk("cs_n", spi_cs_n[k], 1);
      chk("sck", spi_sck[k], 0);
      chk("mosi", spi_mosi[k], 0);
      chk("rsp_valid", rsp_valid[k], 0);
      chk("rsp_data", rsp_data[k], 0);
      r0[k] = rises[k];
      c0[k] = cslow[k];
    end
    $display("reset check done");

    cur_tag = "idle";
    repeat (100) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("idle_sck_edges", rises[k] - r0[k], 0);
      chk("idle_cs_low", cslow[k] - c0[k], 0);
    end
    $display("idle 100 cycles done");

    tbl[0] = '{0, 24'h000010, 2'd0, 161, 32'h0000005A};
    tbl[1] = '{0, 24'h123456, 2'd3, 257, 32'hFCFDF2F3};
    tbl[2] = '{1, 24'h0000FF, 2'd1,  97, 32'h0000A55A};
    tbl[3] = '{0, 24'hFFFFFF, 2'd2, 225, 32'h00A4A55A};
    tbl[4] = '{1, 24'hABCDEF, 2'd3, 129, 32'h5754554A};
    tbl[5] = '{1, 24'h000010, 2'd0,  81, 32'h0000005A};
    for (int i = 0; i < 6; i++) begin
      cur_tag = $sformatf("tbl%0d", i);
      do_read(tbl[i].idx, tbl[i].addr, tbl[i].nb, tbl[i].lat, tbl[i].data);
    end

    // Back-to-back: req_valid stays high across two requests on the CLK_DIV=2 instance.
    cur_tag = "b2b";
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0] = 24'h00ABCD;
    req_nbytes[0] = 2'd1;
    budget = 1000;
    while (!req_ready[0] && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) timeout("accept1");
    t1 = cyc;
    @(negedge clk);
    req_addr[0] = 24'h000010;
    req_nbytes[0] = 2'd0;
    budget = 2000;
    while (!rsp_valid[0] && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) timeout("rsp1");
    t_done = cyc;
    chk("first_latency", t_done - t1, exp_lat(0, 1));
    chk("first_data", rsp_data[0], exp_data(24'h00ABCD, 1));
    hi_cnt = 0;
    cs_glitch = 1'b0;
    budget = 100;
    while (!req_ready[0] && budget > 0) begin
      if (spi_cs_n[0]) hi_cnt++; else cs_glitch = 1'b1;
      @(negedge clk);
      budget--;
    end
    if (budget == 0) timeout("accept2");
    if (spi_cs_n[0]) hi_cnt++; else cs_glitch = 1'b1;
    t2 = cyc;
    chk("second_accept", t2 - t_done, 3);
    chk("cs_gap_min2", hi_cnt >= 2, 1);
    chk("cs_no_glitch", cs_glitch, 0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    budget = 2000;
    while (!rsp_valid[0] && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) timeout("rsp2");
    chk("second_latency", cyc - t2, exp_lat(0, 0));
    chk("second_data", rsp_data[0], 32'h0000005A);
    $display("b2b accept1=%0d done=%0d accept2=%0d cs_high=%0d", t1, t_done, t2, hi_cnt);
    budget = 100;
    while (!req_ready[0] && budget > 0) begin @(negedge clk); budget--; end

    // Asynchronous reset during the address phase aborts the transfer silently.
    cur_tag = "midreset";
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0] = 24'h0A0B0C;
    req_nbytes[0] = 2'd1;
    budget = 100;
    while (!req_ready[0] && budget > 0) begin @(negedge clk); budget--; end
    r0[0] = rises[0];
    rv0 = rspcnt[0];
    @(negedge clk);
    req_valid[0] = 1'b0;
    budget = 500;
    while ((rises[0] - r0[0]) < 19 && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) timeout("addr_bit");
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", spi_cs_n[0], 1);
    chk("abort_sck", spi_sck[0], 0);
    chk("abort_rsp_valid", rsp_valid[0], 0);
    chk("abort_ready", req_ready[0], 1);
    repeat (3) @(negedge clk);
    chk("abort_rsp_data", rsp_data[0], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_rsp", rspcnt[0] - rv0, 0);
    $display("midreset aborted after %0d sck rises", rises[0] - r0[0]);
    do_read(0, 24'h0A0B0C, 2'd1, exp_lat(0, 1), exp_data(24'h0A0B0C, 1));

    for (int i = 0; i < 12; i++) begin
      int          idx;
      logic [23:0] a;
      int          nb;
      idx = int'($urandom_range(0, 1));
      a = 24'($urandom);
      nb = int'($urandom_range(0, 3));
      cur_tag = $sformatf("rnd%0d", i);
      do_read(idx, a, 2'(nb), exp_lat(idx, nb), exp_data(a, nb));
    end

    cur_tag = "pins";
    repeat (2) @(negedge clk);
    chk("pin_invariants_div2", viol[0], 0);
    chk("pin_invariants_div1", viol[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
